// File: rtl/mux_pipe_reg.sv
// Pipeline register with asynchronous active-low clear.
// The top module uses one instance of it to hold the selected data and the select line.
module mux_pipe_reg #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/multiplexer.sv
// 2:1 datapath multiplexer with a combinational output and a one-cycle registered copy.
// The registered copy holds both the selected data and the select line.
module multiplexer #(
    parameter int inputWidth = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [inputWidth-1:0] in0,
    input  logic [inputWidth-1:0] in1,
    input  logic                  select,
    output logic [inputWidth-1:0] out,
    output logic [inputWidth-1:0] out_reg,
    output logic                  select_reg
);

    logic [inputWidth-1:0] w_sel_data;
    logic [inputWidth:0]   w_pipe_q;

    // The conditional operator lets an X/Z select merge in0 and in1 bit by bit.
    assign w_sel_data = select ? in1 : in0;
    assign out        = w_sel_data;

    mux_pipe_reg #(
        .WIDTH(inputWidth + 1)
    ) u_pipe (
        .clk  (clk),
        .rst_n(rst_n),
        .i_d  ({select, w_sel_data}),
        .o_q  (w_pipe_q)
    );

    assign select_reg = w_pipe_q[inputWidth];
    assign out_reg    = w_pipe_q[inputWidth-1:0];

endmodule

// File: tb/tb_multiplexer.sv
// Directed bench for multiplexer at widths 8, 16 and 1.
// All three instances share one clock and one reset.
module tb_multiplexer;

  logic clk;
  logic clk_en;
  logic rst_n;

  logic [7:0]  in0_8, in1_8, out_8, out_reg_8;
  logic        sel_8, sel_reg_8;
  logic [15:0] in0_16, in1_16, out_16, out_reg_16;
  logic        sel_16, sel_reg_16;
  logic [0:0]  in0_1, in1_1, out_1, out_reg_1;
  logic        sel_1, sel_reg_1;

  int checks;
  int failures;

  multiplexer #(.inputWidth(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in0(in0_8), .in1(in1_8), .select(sel_8),
    .out(out_8), .out_reg(out_reg_8), .select_reg(sel_reg_8)
  );

  multiplexer #(.inputWidth(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in0(in0_16), .in1(in1_16), .select(sel_16),
    .out(out_16), .out_reg(out_reg_16), .select_reg(sel_reg_16)
  );

  multiplexer #(.inputWidth(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in0(in0_1), .in1(in1_1), .select(sel_1),
    .out(out_1), .out_reg(out_reg_1), .select_reg(sel_reg_1)
  );

  // Clock only toggles once enabled, so the first test runs with no clock at all.
  always #5 if (clk_en) clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_comb_no_clock();
    in0_8 = 8'hFF; in1_8 = 8'h00; sel_8 = 1'b0;
    #1;
    checks++;
    if (out_8 !== 8'hFF) begin
      failures++; $display("FAIL comb_sel0: out=%h exp=%h", out_8, 8'hFF);
    end
    #5;
    sel_8 = 1'b1;
    #1;
    checks++;
    if (out_8 !== 8'h00) begin
      failures++; $display("FAIL comb_sel1: out=%h exp=%h", out_8, 8'h00);
    end
    #5;
    in1_8 = 8'hAA;
    #1;
    checks++;
    if (out_8 !== 8'hAA) begin
      failures++; $display("FAIL comb_in1_change: out=%h exp=%h", out_8, 8'hAA);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_reg_8 !== 8'h00 || sel_reg_8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_8: out_reg=%h sel_reg=%b exp=00/0", out_reg_8, sel_reg_8);
    end
    checks++;
    if (out_reg_16 !== 16'h0000 || sel_reg_16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_16: out_reg=%h sel_reg=%b exp=0000/0", out_reg_16, sel_reg_16);
    end
    // Registers must keep zero across clock edges while reset stays low.
    in0_8 = 8'h5A; sel_8 = 1'b0;
    clk_en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_reg_8 !== 8'h00 || sel_reg_8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: out_reg=%h sel_reg=%b exp=00/0", out_reg_8, sel_reg_8);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    in0_8 = 8'h3C; in1_8 = 8'h00; sel_8 = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (out_reg_8 !== 8'h00) begin
      failures++; $display("FAIL pre_first_edge: out_reg=%h exp=%h", out_reg_8, 8'h00);
    end
    @(posedge clk); #1;
    checks++;
    if (out_reg_8 !== 8'h3C || sel_reg_8 !== 1'b0) begin
      failures++;
      $display("FAIL first_capture: out_reg=%h sel_reg=%b exp=3c/0", out_reg_8, sel_reg_8);
    end
    @(negedge clk);
    sel_8 = 1'b1; in1_8 = 8'hC3;
    #1;
    checks++;
    if (out_reg_8 !== 8'h3C || out_8 !== 8'hC3) begin
      failures++;
      $display("FAIL before_second_edge: out_reg=%h out=%h exp=3c/c3", out_reg_8, out_8);
    end
    @(posedge clk); #1;
    checks++;
    if (out_reg_8 !== 8'hC3 || sel_reg_8 !== 1'b1) begin
      failures++;
      $display("FAIL second_capture: out_reg=%h sel_reg=%b exp=c3/1", out_reg_8, sel_reg_8);
    end
  endtask

  task automatic test_async_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_reg_8 !== 8'h00 || sel_reg_8 !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: out_reg=%h sel_reg=%b exp=00/0", out_reg_8, sel_reg_8);
    end
    checks++;
    if (out_8 !== 8'hC3) begin
      failures++; $display("FAIL comb_during_reset: out=%h exp=%h", out_8, 8'hC3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] v0 [4];
    logic [7:0] v1 [4];
    logic       vs [4];
    logic [7:0] ex [4];
    v0[0] = 8'h11; v1[0] = 8'h22; vs[0] = 1'b1; ex[0] = 8'h22;
    v0[1] = 8'h33; v1[1] = 8'h44; vs[1] = 1'b0; ex[1] = 8'h33;
    v0[2] = 8'h55; v1[2] = 8'h66; vs[2] = 1'b0; ex[2] = 8'h55;
    v0[3] = 8'h77; v1[3] = 8'h88; vs[3] = 1'b1; ex[3] = 8'h88;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in0_8 = v0[i]; in1_8 = v1[i]; sel_8 = vs[i];
      @(posedge clk); #1;
      checks++;
      if (out_reg_8 !== ex[i] || sel_reg_8 !== vs[i]) begin
        failures++;
        $display("FAIL back_to_back[%0d]: out_reg=%h sel_reg=%b exp=%h/%b",
                 i, out_reg_8, sel_reg_8, ex[i], vs[i]);
      end
    end
  endtask

  task automatic test_width16();
    logic [15:0] prev;
    logic [15:0] exp_out;
    @(negedge clk);
    in0_16 = 16'h1234; in1_16 = 16'hABCD; sel_16 = 1'b0;
    #1;
    checks++;
    if (out_16 !== 16'h1234) begin
      failures++; $display("FAIL w16_init: out=%h exp=%h", out_16, 16'h1234);
    end
    @(posedge clk); #1;
    prev = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sel_16 = ~sel_16;
      exp_out = sel_16 ? 16'hABCD : 16'h1234;
      #1;
      checks++;
      if (out_16 !== exp_out || out_reg_16 !== prev) begin
        failures++;
        $display("FAIL w16_toggle[%0d]: out=%h out_reg=%h exp=%h/%h",
                 i, out_16, out_reg_16, exp_out, prev);
      end
      @(posedge clk); #1;
      checks++;
      if (out_reg_16 !== exp_out || sel_reg_16 !== sel_16) begin
        failures++;
        $display("FAIL w16_reg[%0d]: out_reg=%h sel_reg=%b exp=%h/%b",
                 i, out_reg_16, sel_reg_16, exp_out, sel_16);
      end
      prev = exp_out;
    end
  endtask

  task automatic test_width1();
    // Bit i of the table is the expected out for {in0,in1,select} == i.
    logic [7:0] truth;
    logic [2:0] idx;
    truth = 8'b1101_1000;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      @(negedge clk);
      in0_1 = idx[2]; in1_1 = idx[1]; sel_1 = idx[0];
      #1;
      checks++;
      if (out_1 !== truth[i]) begin
        failures++;
        $display("FAIL w1_comb[%0d]: out=%b exp=%b", i, out_1, truth[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (out_reg_1 !== truth[i] || sel_reg_1 !== idx[0]) begin
        failures++;
        $display("FAIL w1_reg[%0d]: out_reg=%b sel_reg=%b exp=%b/%b",
                 i, out_reg_1, sel_reg_1, truth[i], idx[0]);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    clk = 1'b0; clk_en = 1'b0; rst_n = 1'b0;
    in0_8 = '0; in1_8 = '0; sel_8 = 1'b0;
    in0_16 = '0; in1_16 = '0; sel_16 = 1'b0;
    in0_1 = '0; in1_1 = '0; sel_1 = 1'b0;

    test_comb_no_clock();
    test_reset();
    test_registered();
    test_async_reset_mid();
    test_back_to_back();
    test_width16();
    test_width1();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiplexer.md
Name: multiplexer

Overview:
- Parameterised 2:1 data-path multiplexer for the microprocessor datapath, used for operand and result selection.
- Primary output `out` is purely combinational; it must settle within the same delta cycle as any input change, with no clock required.
- A registered copy of the selected data and of the select line is also provided. Consumers needing a timing-clean version use these; they are clocked by the single system clock and asynchronously cleared.

Parameters:
- inputWidth, 8, bit width of in0, in1, out and out_reg; legal range 1..64. The name is fixed because existing instantiations override it by name.

Ports:
- clk  input  1  system clock; rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in0  input  inputWidth  data input selected when select=0
- in1  input  inputWidth  data input selected when select=1
- select  input  1  selection control
- out  output  inputWidth  combinational selected data
- out_reg  output  inputWidth  registered selected data
- select_reg  output  1  registered select

Behaviour:
- Combinational path:
  - out = in1 when select=1, else in0.
  - Zero cycles of latency; out follows changes on in0, in1 and select immediately.
  - out does not depend on clk or rst_n; it is valid during reset and with no clock running.
- Unknown select:
  - In simulation, select=X/Z drives out bitwise: bits where in0 and in1 agree take that value, all other bits are X (standard conditional-operator semantics).
  - No latch may be inferred.
- Registered path:
  - On each rising edge of clk with rst_n=1: out_reg <= out, select_reg <= select.
  - Latency is exactly one cycle from the input values present at the edge.
- Reset:
  - rst_n=0 forces out_reg=0 and select_reg=0 immediately, independent of clk.
  - Registers hold 0 while rst_n stays low.
  - The first capture occurs on the first rising clk edge after rst_n returns high.
- Reset mid-operation: asserting rst_n at any point clears the registered outputs asynchronously; the combinational out is unaffected.
- Simultaneous events: when in0, in1 and select change in the same timestep, out reflects only the final values, with no glitch requirement beyond zero-delay semantics. The register captures the values settled before the edge.
- Width rules:
  - All data paths are exactly inputWidth bits, with no sign or zero extension.
  - With inputWidth=1 the block reduces to a single-bit mux.
- No handshake and no state machine.

Decomposition:
- No shared package is required; the only constant is the inputWidth default, kept local.
- One natural sub-module, mux_pipe_reg: an inputWidth+1-bit register with async active-low clear, instantiated once for {select, out}.
- The combinational select stays in the top module.

Test Plan:
- inputWidth=8, in0=8'hFF, in1=8'h00, select=0, no clock -> out=8'hFF.
- After 5 ns, select=1 -> out=8'h00 within the same timestep. After a further 5 ns, in1=8'hAA -> out=8'hAA.
- Clocked run:
  - rst_n=0 -> out_reg=8'h00 and select_reg=0.
  - Release rst_n with in0=8'h3C and select=0; on the first rising edge -> out_reg=8'h3C, select_reg=0.
  - Next edge with select=1, in1=8'hC3 -> out_reg=8'hC3, select_reg=1.
- Drop rst_n between clock edges while out_reg=8'hC3 -> out_reg=8'h00 immediately, while out still equals 8'hC3.
- Override inputWidth=16: in0=16'h1234, in1=16'hABCD; toggle select 0/1 -> out alternates 16'h1234 / 16'hABCD, and out_reg follows one cycle later.
- Override inputWidth=1: exhaustive sweep of the 8 combinations of in0, in1 and select -> out matches the truth table in every case.
